// File: rtl/iter_shifter_pkg.sv
// Shared types for the iterative shift unit.
// Op encodings and FSM state type.
package iter_shifter_pkg;

  localparam logic [1:0] SHOP_SLL = 2'b00;
  localparam logic [1:0] SHOP_SRL = 2'b01;
  localparam logic [1:0] SHOP_ROR = 2'b10;
  localparam logic [1:0] SHOP_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/iter_shifter_step.sv
// One combinational shift step of 0..STEP positions.
// ROR is built only with ITER_SHIFTER_ROTATE_EN defined.
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic [XLEN-1:0]           value_i,
  input  logic [1:0]                op_i,
  input  logic                      sign_i,
  input  logic [$clog2(STEP+1)-1:0] k_i,
  output logic [XLEN-1:0]           value_o
);

  localparam int SW = $clog2(XLEN+1);

  logic [SW-1:0]   kx;
  logic [SW-1:0]   kc;
  logic [XLEN-1:0] fill;

  assign kx = SW'(k_i);
  assign kc = SW'(XLEN) - kx;
  // k==0 gives kc==XLEN, which shifts the fill mask fully out
  assign fill = {XLEN{sign_i}} << kc;

  always_comb begin
    value_o = value_i;
    case (op_i)
      SHOP_SLL: value_o = value_i << kx;
      SHOP_SRL: value_o = value_i >> kx;
      SHOP_SRA: value_o = (value_i >> kx) | fill;
`ifdef ITER_SHIFTER_ROTATE_EN
      SHOP_ROR: value_o = (value_i >> kx) | (value_i << kc);
`else
      SHOP_ROR: value_o = value_i;
`endif
      default:  value_o = value_i;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA unit, STEP bits per cycle.
// Optional ROR on op 10 via ITER_SHIFTER_ROTATE_EN.
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [XLEN-1:0]          operand,
  input  logic [$clog2(XLEN)-1:0]  shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          result
);

  localparam int SAW = $clog2(XLEN);
  localparam int KW  = $clog2(STEP+1);

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] val_q, val_d;
  logic [XLEN-1:0] step_val;
  logic            sign_q, sign_d;
  logic [SAW-1:0]  rem_q, rem_d;
  logic [KW-1:0]   k;

  assign k = ({1'b0, rem_q} >= (SAW+1)'(STEP))
           ? KW'(STEP) : KW'(rem_q);

  shift_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .value_i (val_q),
    .op_i    (op_q),
    .sign_i  (sign_q),
    .k_i     (k),
    .value_o (step_val)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    val_d   = val_q;
    sign_d  = sign_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          val_d   = operand;
          sign_d  = operand[XLEN-1];
          rem_d   = shamt;
          state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        val_d = step_val;
        rem_d = rem_q - SAW'(k);
        if (rem_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= SHOP_SLL;
      val_q   <= '0;
      sign_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      val_q   <= val_d;
      sign_q  <= sign_d;
      rem_q   <= rem_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = val_q;

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Parametrised multi-cycle shift unit for the RV32I core's execute stage. It executes SLL/SRL/SRA and their immediate forms (SLLI/SRLI/SRAI) over a configurable datapath width. The result is produced iteratively, STEP bit positions per cycle, behind valid/ready handshakes. It trades the single-cycle 32-bit barrel shifter for area, and adds optional rotate support.

## Interface
- XLEN, 32, operand/result width; power of two, 8..64
- STEP, 4, max bit positions shifted per cycle; power of two, 1..XLEN
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- op  input  2  00 SLL, 01 SRL, 11 SRA, 10 ROR (see Configuration)
- operand  input  XLEN  value to shift
- shamt  input  $clog2(XLEN)  shift amount; unsigned; upper bits of rs2/imm discarded by the caller
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- result  output  XLEN  shifted value; registered

## Operation
- One clock, `clk`; reset is synchronous and active-high (`reset`).
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture op, operand and shamt into working registers, and set remaining=shamt. Go to DONE if shamt==0, else go to SHIFT.
  - SHIFT: each cycle shift working value by k=min(STEP, remaining), then remaining -= k. When remaining reaches 0 after this cycle, go to DONE.
  - DONE: out_valid=1, result=working value. On out_ready, go to IDLE.
- Fill rules:
  - SLL shifts zeros in at the LSB.
  - SRL shifts zeros in at the MSB.
  - SRA replicates the operand[XLEN-1] captured at accept, so the fill does not depend on intermediate values.
- in_ready is 1 only in IDLE; no new request is accepted while SHIFT or DONE.
- Inputs are sampled only at the accept edge. Later changes to op, operand or shamt have no effect.
- result and out_valid are stable while out_valid=1 and out_ready=0.
- shamt is never wider than $clog2(XLEN), so over-range shifts cannot occur.
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, remaining 0.
- Reset mid-operation (SHIFT or DONE): the operation is discarded with no output. Next cycle is IDLE with out_valid 0 and result 0.
- If reset and in_valid are both high, reset wins and nothing is captured.

## Timing
- Accept edge T: rising edge with in_valid && in_ready && !reset.
- N = ceil(shamt/STEP). out_valid is 1 in the cycle after edge T+N, so shamt==0 gives out_valid right after T.
- Release: at the edge where out_valid && out_ready, the unit goes to IDLE. in_ready is 1 in the following cycle.
- No overlap between release and accept, so minimum request spacing is N+2 cycles.
- Example, XLEN=32, STEP=4, shamt=31: N=8, with 7 steps of 4 followed by 1 step of 3.
- Example, STEP=XLEN: N≤1, giving a barrel-equivalent with 1-cycle latency.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.

## Configuration
- ITER_SHIFTER_ROTATE_EN defined: op 10 performs ROR, rotating right with bits leaving the LSB entering the MSB. Latency is the same as for shifts.
- ITER_SHIFTER_ROTATE_EN undefined: op 10 is reserved. The request completes with latency N and result=operand unchanged. No rotate logic is synthesised.

## Structure
- Package iter_shifter_pkg holds:
  - the op encoding constants SHOP_SLL, SHOP_SRL, SHOP_ROR, SHOP_SRA
  - the state typedef for IDLE/SHIFT/DONE
- Sub-module shift_step: combinational, one step. It takes value, op, sign bit and k (0..STEP) and returns the value shifted by k.
- iter_shifter holds the FSM, working registers and the remaining counter, and instantiates one shift_step.

## Test plan
- SRA, XLEN=32, STEP=4, operand 0xFFFFFFFC, shamt 1 → result 0xFFFFFFFE; out_valid one edge after accept.
- SRA, operand 0x80000000, shamt 31 → result 0xFFFFFFFF; out_valid exactly 8 edges after accept. SRL with the same inputs → 0x00000001.
- SLL, operand 0x00000001, shamt 31 → 0x80000000. SLL with shamt 0 → 0x00000001 right after the accept edge.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. result stays constant, in_ready stays 0, and in_valid pulses are ignored. Release, then accept the next request on the following cycle.
- Reset on the 3rd SHIFT cycle of an SRA with shamt 20: next cycle shows out_valid 0, result 0, in_ready 1. A fresh request then completes correctly.
- Rotate, op 10, operand 0x00000001, shamt 1: → 0x80000000 with ITER_SHIFTER_ROTATE_EN defined; → 0x00000001 without it.
